// File: rtl/syn_pcm_mc_cache.sv
// Multi-channel PCM frame cache: continuous FIFO (NORMAL) or one-shot fill-then-drain snapshot (CAPTURE).
// Frame memory with a registered read feeding a show-ahead output register.
module syn_pcm_mc_cache #(
    parameter int NUM_CHNNLS = 2,
    parameter int PCM_DATA_W = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_mode,
    input  logic                             cfg_bps,
    input  logic                             cap_start,
    input  logic                             ovf_clr,
    input  logic                             wr_valid,
    input  logic [NUM_CHNNLS*PCM_DATA_W-1:0] wr_data,
    output logic                             wr_ready,
    output logic                             rd_valid,
    output logic [NUM_CHNNLS*PCM_DATA_W-1:0] rd_data,
    input  logic                             rd_ready,
    output logic [ADDR_W:0]                  fill_cnt,
    output logic                             cap_busy,
    output logic                             ovf,
    output logic [1:0]                       dbg_cap_state
);
    localparam int FW = NUM_CHNNLS * PCM_DATA_W;
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } cap_state_e;

    cap_state_e        state_q, state_d;
    logic              mode_q, started_q;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d, mem_cnt;
    logic [FW-1:0]     out_q, out_d, wr_fmt;
    logic [PCM_DATA_W-1:0] chan;
    logic              mode_chg, cap_flush, flush;
    logic              wr_allow, rd_allow, push, pop, load, ovf_set;

    logic [FW-1:0] mem [DEPTH];

    // Handshake: a frame moves on any cycle with valid && ready; valid never waits on ready,
    // and rd_valid/rd_data stay put until the consumer takes the frame.
    assign mode_chg = (cfg_mode != mode_q);
    assign wr_allow = !mode_q || (state_q == ST_FILL);
    assign rd_allow = !mode_q || (state_q == ST_DRAIN);
    assign wr_ready = started_q && (fill_q < FULL_C) && wr_allow;
    assign rd_valid = out_valid_q && rd_allow;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    // Frames still in memory exclude the one parked in the output register.
    assign mem_cnt  = fill_q - (ADDR_W+1)'(out_valid_q);
    assign load     = (mem_cnt != '0) && (!out_valid_q || pop);
    assign ovf_set  = !mode_q && wr_valid && (fill_q == FULL_C);

    always_comb begin
        wr_fmt = '0;
        chan   = '0;
        for (int c = 0; c < NUM_CHNNLS; c++) begin
            chan = wr_data[c*PCM_DATA_W +: PCM_DATA_W];
            if (!cfg_bps) begin
                for (int b = 16; b < PCM_DATA_W; b++) chan[b] = chan[15];
            end
            wr_fmt[c*PCM_DATA_W +: PCM_DATA_W] = chan;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_flush = 1'b0;
        if (!mode_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cap_start) begin
                        state_d   = ST_FILL;
                        cap_flush = 1'b1;
                    end
                end
                ST_FILL:  if (fill_q == FULL_C) state_d = ST_DRAIN;
                ST_DRAIN: if (pop && (fill_q == ONE_C)) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        if (mode_chg) begin
            state_d = ST_IDLE;
        end
    end

    assign flush = mode_chg || cap_flush;

    always_comb begin
        wr_ptr_d    = flush ? '0 : wr_ptr_q + ADDR_W'(push);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + ADDR_W'(load);
        fill_d      = flush ? '0 : fill_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (load) begin
            out_d       = mem[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_fmt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            started_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= cfg_mode;
            started_q   <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rd_data       = out_q;
    assign fill_cnt      = fill_q;
    assign cap_busy      = (state_q != ST_IDLE);
    assign ovf           = ovf_q;
    assign dbg_cap_state = state_q;

endmodule

// File: doc/syn_pcm_mc_cache.md
# syn_pcm_mc_cache

Parametrised multi-channel PCM frame cache sitting between the audio codec interface (ADC capture path) and the downstream consumer (DAC driver or host readout). It buffers frames of NUM_CHNNLS samples and supports 16- and 32-bit sample modes. It has two operating modes: NORMAL, a continuous streaming FIFO, and CAPTURE, a one-shot fill-then-drain snapshot. It generalises the two-channel fixed-width PCM frame with per-channel count, depth and a capture state machine.

## Interface
- NUM_CHNNLS, 2, channels per frame (≥1)
- PCM_DATA_W, 32, bits per channel sample slot (≥16)
- DEPTH, 128, frame capacity, power of 2 (≥4)
- ADDR_W, $clog2(DEPTH), pointer width (derived)

- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- cfg_mode  in  1  0 = NORMAL, 1 = CAPTURE
- cfg_bps  in  1  0 = BPS_16, 1 = BPS_32
- cap_start  in  1  single-cycle pulse that arms a capture (CAPTURE mode only)
- ovf_clr  in  1  pulse that clears the ovf flag
- wr_valid  in  1  input frame valid
- wr_data  in  NUM_CHNNLS*PCM_DATA_W  input frame; channel 0 in the LSBs
- wr_ready  out  1  cache accepts a frame
- rd_valid  out  1  output frame valid
- rd_data  out  NUM_CHNNLS*PCM_DATA_W  output frame
- rd_ready  in  1  consumer accepts the frame
- fill_cnt  out  ADDR_W+1  frames held (memory plus output register)
- cap_busy  out  1  capture FSM not in IDLE
- ovf  out  1  sticky overflow flag

## Operation
- Push occurs when wr_valid && wr_ready. Pop occurs when rd_valid && rd_ready.
- Sample format on write, applied per channel:
  - BPS_32: stored unchanged.
  - BPS_16: bits [15:0] kept; bits [PCM_DATA_W-1:16] replaced by sign extension of bit 15.
- Storage: DEPTH-entry frame memory with a registered read, followed by one output register (show-ahead prefetch). fill_cnt ≤ DEPTH always.
- NORMAL mode:
  - wr_ready = (fill_cnt < DEPTH). rd_valid whenever the output register holds a frame.
  - wr_valid while fill_cnt == DEPTH sets ovf; the frame is discarded.
  - The capture FSM is held in IDLE.
- CAPTURE mode FSM, states IDLE, FILL, DRAIN:
  - IDLE: wr_ready = 0, rd_valid = 0. cap_start moves to FILL and flushes the pointers and fill_cnt.
  - FILL: wr_ready = (fill_cnt < DEPTH), rd_valid = 0. Moves to DRAIN on the cycle after fill_cnt reaches DEPTH.
  - DRAIN: wr_ready = 0; frames are output. Moves to IDLE on the cycle after the last pop (fill_cnt = 0).
  - cap_start outside IDLE is ignored. ovf is not set in CAPTURE mode.
- Mode change: any change of cfg_mode, detected against a registered copy, flushes the cache (pointers, fill_cnt, output register) and forces IDLE on the next cycle. ovf is retained.
- cfg_bps changes take effect on the next push. Frames already stored are unaffected.
- ovf_clr clears ovf. If ovf_clr coincides with a new overflow event, the set wins.

## Timing
- Reset values: wr_ready 0 for the first cycle after rst_n deassertion, then per mode. rd_valid 0, rd_data 0, fill_cnt 0, cap_busy 0, ovf 0. FSM in IDLE, mode register 0.
- Latency: a push into an empty cache at cycle N gives rd_valid = 1 at N+2 with that frame on rd_data.
- Throughput: one push and one pop per cycle sustained. A simultaneous push and pop leaves fill_cnt unchanged.
- Outputs are held: rd_data and rd_valid stay stable while rd_valid && !rd_ready.
- fill_cnt updates the cycle after a push or pop. wr_ready is derived from the registered fill_cnt, so there is no same-cycle full bypass.
- Pointers wrap modulo DEPTH with no gap.
- Reset mid-operation: asynchronous clear to the reset values above; contents are discarded.

## Test plan
- Basic NORMAL flow: NUM_CHNNLS = 2, BPS_32. Push 10 frames with incrementing data while rd_ready = 1.
  - Required: identical frames out in order; first rd_valid 2 cycles after the first push; fill_cnt returns to 0.
- BPS_16 extension: push channel 0 = 0x1234_8001 and channel 1 = 0xFFFF_7FFF.
  - Required: output 0xFFFF_8001 and 0x0000_7FFF.
- NORMAL overflow: rd_ready = 0, push DEPTH+3 frames.
  - Required: fill_cnt = DEPTH, wr_ready = 0, ovf = 1; the first DEPTH frames drain intact; ovf_clr then clears ovf.
- CAPTURE cycle: pulse cap_start, stream 2*DEPTH frames.
  - Required: only the first DEPTH frames are accepted; rd_valid stays 0 until DRAIN; all DEPTH frames drain in order; cap_busy falls after the last pop.
- Boundaries:
  - cap_start during FILL: ignored.
  - cfg_mode toggled with 5 frames stored: fill_cnt = 0 and rd_valid = 0 on the next cycle.
  - Simultaneous push/pop at fill_cnt = DEPTH-1: fill_cnt stays at DEPTH-1.
- Asynchronous reset: assert rst_n low mid-DRAIN, between clock edges.
  - Required: all outputs take their reset values immediately; normal operation resumes after release.
